upsizing: RTL
=============

// Module: upsizing
// PURPOSE
//  Narrow-to-wide AXI-Stream width converter: packs two W-bit beats into one 2W-bit beat.
//  Inverse of the 2W->W downsizer: beat 0 goes to the upper half [2W-1:W], beat 1 to the lower half [W-1:0].
//  A downsize->upsize chain is therefore data-transparent.
//  Sits on the receive side of the string datapath (4 symbols in, 8 symbols out).
// PARAMETERS
//  W  32  narrow data width in bits; output width is 2*W
// PORTS
//  aclk        in   1    clock; all state changes on posedge
//  aresetn     in   1    asynchronous, active-low reset
//  in_tdata    in   W    narrow input data
//  in_tvalid   in   1    input beat valid
//  in_tlast    in   1    last narrow beat of a packet
//  in_tready   out  1    input ready (combinational)
//  out_tdata   out  2W   wide output data, registered
//  out_tvalid  out  1    wide beat valid, registered
//  out_tlast   out  1    last wide beat of a packet, registered
//  out_tkeep   out  2    half-valid: [1] = upper half valid, [0] = lower half valid
//  out_tready  in   1    downstream ready
// BEHAVIOUR
//  Handshake and reset
//  - Transfer on valid & ready, both sides.
//  - out_* hold stable while out_tvalid & ~out_tready.
//  - Reset: state=EMPTY, out_tvalid=0, out_tlast=0, out_tkeep=2'b00. out_tdata and hi_q are not reset.
//  - Reset mid-operation discards any captured half and any pending output beat.
//  Definitions and FSM
//  - out_free = ~out_tvalid | out_tready.
//  - EMPTY: in_tready=1.
//      Accept, ~in_tlast: hi_q<=in_tdata -> HALF.
//      Accept, in_tlast, out_free: load out={in_tdata,W'0}, keep=2'b10, last=1 -> EMPTY.
//      Accept, in_tlast, ~out_free: hi_q<=in_tdata -> FLUSH.
//  - HALF: in_tready=out_free.
//      Accept: load out={hi_q,in_tdata}, keep=2'b11, last=in_tlast -> EMPTY.
//  - FLUSH: in_tready=0.
//      When out_free: load out={hi_q,W'0}, keep=2'b10, last=1 -> EMPTY.
//  Output register
//  - A load sets out_tvalid=1.
//  - out_tvalid clears when out_tready & out_tvalid and no load happens in the same cycle.
//  - Simultaneous drain + load keeps out_tvalid=1 with the new data.
//  Latency and throughput
//  - Wide beat is visible 1 cycle after the accept of its last narrow beat.
//  - Sustains 1 narrow beat/cycle (1 wide beat per 2 cycles) with out_tready=1.
//  - FLUSH costs at most the downstream stall plus 1 cycle.
//  Ordering and padding
//  - Padding half is always zero.
//  - Packets never share a wide beat: in_tlast always closes the current wide beat.
//  - in_tready never depends on in_tvalid or in_tlast.
// STRUCTURE
//  - Shared package upsizing_pkg:
//      typedef enum logic [1:0] {EMPTY, HALF, FLUSH} ups_state_t;
//      localparams KEEP_FULL=2'b11, KEEP_HI=2'b10.
//  - Single module, no sub-module. Registers: state, hi_q[W], output register set.
// TESTING (W=32)
//  1. Reset held, then released, in_tvalid=0 -> out_tvalid=0, out_tkeep=0, in_tready=1.
//  2. Beats 32'hAAAA0001, 32'h00000002 (last), out_tready=1
//     -> out_tdata=64'hAAAA0001_00000002, keep=11, last=1, one cycle after beat 2.
//  3. Single beat 32'h12345678 with in_tlast, out_tready=1
//     -> out=64'h12345678_00000000, keep=10, last=1.
//  4. Single-beat tlast while the output holds a stalled beat (out_tready=0 for 3 cycles)
//     -> FLUSH, in_tready=0; pad beat follows the stalled beat in order; no data lost.
//  5. 64 random beats, random out_tready and in_tvalid, tlast at odd/even positions
//     -> scoreboard vs. reference packer; out stable under stall; 1 beat/cycle when unthrottled.
//  6. aresetn pulsed low in HALF and with out_tvalid=1
//     -> out_tvalid=0 immediately (asynchronous); next packet packs from the upper half.

Source files
------------

// File: rtl/upsizing_pkg.sv
// Shared types and constants for the narrow-to-wide stream upsizer.
package upsizing_pkg;

  typedef enum logic [1:0] {EMPTY, HALF, FLUSH} ups_state_t;

  localparam logic [1:0] KEEP_FULL = 2'b11;
  localparam logic [1:0] KEEP_HI   = 2'b10;
  localparam logic [1:0] KEEP_NONE = 2'b00;

endpackage

// File: rtl/upsizing_if.sv
// AXI-Stream style link; DW is the data width on this side of the upsizer.
interface upsizing_if #(parameter int DW = 32);

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic [1:0]    tkeep;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);

endinterface

// File: rtl/upsizing.sv
// Packs pairs of W-bit beats into 2W-bit beats; first beat lands in the upper half.
// A lone tlast beat is padded with a zero lower half so packets never share a wide beat.
module upsizing
  import upsizing_pkg::*;
#(
  parameter int W = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  upsizing_if.slave   narrow,
  upsizing_if.master  wide
);

  // state | meaning
  // EMPTY | no half captured, ready for a new upper half
  // HALF  | upper half in hi_q, waiting for the lower half
  // FLUSH | lone tlast beat in hi_q, waiting for output space to emit it padded

  ups_state_t   state;
  logic [W-1:0] hi_q;

  logic out_free;
  logic accept;
  logic load_pair;
  logic load_single;
  logic load_flush;
  logic capture;
  logic load;

  assign out_free     = ~wide.tvalid | wide.tready;
  assign narrow.tready = (state == EMPTY) | ((state == HALF) & out_free);
  assign accept       = narrow.tvalid & narrow.tready;

  assign load_pair   = accept & (state == HALF);
  assign load_single = accept & (state == EMPTY) & narrow.tlast & out_free;
  assign capture     = accept & (state == EMPTY) & (~narrow.tlast | ~out_free);
  assign load_flush  = (state == FLUSH) & out_free;
  assign load        = load_pair | load_single | load_flush;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= EMPTY;
      wide.tvalid <= 1'b0;
      wide.tlast  <= 1'b0;
      wide.tkeep  <= KEEP_NONE;
    end else begin
      if (load) begin
        wide.tvalid <= 1'b1;
      end else if (wide.tready) begin
        wide.tvalid <= 1'b0;
      end

      unique case (state)
        EMPTY: begin
          if (load_single) begin
            wide.tkeep <= KEEP_HI;
            wide.tlast <= 1'b1;
          end else if (capture) begin
            state <= narrow.tlast ? FLUSH : HALF;
          end
        end
        HALF: begin
          if (load_pair) begin
            wide.tkeep <= KEEP_FULL;
            wide.tlast <= narrow.tlast;
            state      <= EMPTY;
          end
        end
        FLUSH: begin
          if (load_flush) begin
            wide.tkeep <= KEEP_HI;
            wide.tlast <= 1'b1;
            state      <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Datapath registers carry no reset; validity is tracked by the control flops above.
  always_ff @(posedge aclk) begin
    if (capture) begin
      hi_q <= narrow.tdata;
    end
    if (load_pair) begin
      wide.tdata <= {hi_q, narrow.tdata};
    end else if (load_single) begin
      wide.tdata <= {narrow.tdata, {W{1'b0}}};
    end else if (load_flush) begin
      wide.tdata <= {hi_q, {W{1'b0}}};
    end
  end

endmodule
